// File: rtl/regdest_wr_arbiter_if.sv
// Writeback request / register-file write-port bundle for regdest_wr_arbiter.
// master: requesters plus register-file side (drives requests, stall, flush).
// slave : the arbiter itself.
interface regdest_wr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 5
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [4*NUM_REQ-1:0]      req_sel;
    logic [ADDR_W*NUM_REQ-1:0] req_addr;
    logic [DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      wr_stall;
    logic                      flush;
    logic                      wr_en;
    logic [3:0]                wr_sel;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic [2:0]                wr_src;
    logic                      err_sel;
    logic [15:0]               stat_stall_cnt;

    modport master (
        output req_valid, req_sel, req_addr, req_data, wr_stall, flush,
        input  req_ready, wr_en, wr_sel, wr_addr, wr_data, wr_src, err_sel, stat_stall_cnt
    );

    modport slave (
        input  req_valid, req_sel, req_addr, req_data, wr_stall, flush,
        output req_ready, wr_en, wr_sel, wr_addr, wr_data, wr_src, err_sel, stat_stall_cnt
    );
endinterface

// File: rtl/regdest_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among
// NUM_REQ writeback requesters. Grants are combinational; the write port is
// registered, held across register-file stalls, and discarded on flush.
// Optional: define REGDEST_STALL_STATS_EN to build the saturating stall counter
// behind stat_stall_cnt (otherwise the port reads constant 0).
module regdest_wr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned MAX_SEL = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regdest_wr_arbiter_if.slave     bus
);
    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned SEL_W = 4;
    localparam int unsigned SRC_W = 3;
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              wr_en_q, wr_en_d;
    logic [SEL_W-1:0]  wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [SRC_W-1:0]  wr_src_q, wr_src_d;
    logic              err_sel_q, err_sel_d;

    logic              can_accept_c;
    logic              gnt_hit_c;
    logic [PTR_W-1:0]  gnt_idx_c;
    logic [NUM_REQ-1:0] grant_c;
    int unsigned       scan_idx;

    logic [SEL_W-1:0]  sel_arr  [NUM_REQ];
    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    // Split the flat per-requester buses into indexable arrays
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign sel_arr[gi]  = bus.req_sel[SEL_W*gi +: SEL_W];
        assign addr_arr[gi] = bus.req_addr[ADDR_W*gi +: ADDR_W];
        assign data_arr[gi] = bus.req_data[DATA_W*gi +: DATA_W];
    end

    // Round-robin search from rr_ptr, wrapping modulo NUM_REQ; one-hot grant
    always_comb begin
        can_accept_c = !bus.flush && ((state_q == ST_IDLE) || !bus.wr_stall);
        grant_c      = '0;
        gnt_idx_c    = '0;
        gnt_hit_c    = 1'b0;
        scan_idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (can_accept_c && !gnt_hit_c && bus.req_valid[PTR_W'(scan_idx)]) begin
                gnt_hit_c = 1'b1;
                gnt_idx_c = PTR_W'(scan_idx);
            end
        end
        if (gnt_hit_c) begin
            grant_c[gnt_idx_c] = 1'b1;
        end
    end

    assign bus.req_ready = grant_c;

    // Next-state and write-port capture: flush > stall hold > handshake > idle
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = wr_en_q;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_src_d  = wr_src_q;
        err_sel_d = 1'b0;

        if (bus.flush) begin
            state_d  = ST_IDLE;
            wr_en_d  = 1'b0;
            rr_ptr_d = '0;
        end else if ((state_q != ST_IDLE) && bus.wr_stall) begin
            state_d = ST_HOLD;
        end else if (gnt_hit_c) begin
            rr_ptr_d = (gnt_idx_c == LAST_IDX) ? '0 : gnt_idx_c + PTR_W'(1);
            if (32'(sel_arr[gnt_idx_c]) <= MAX_SEL) begin
                state_d   = ST_WRITE;
                wr_en_d   = 1'b1;
                wr_sel_d  = sel_arr[gnt_idx_c];
                wr_addr_d = addr_arr[gnt_idx_c];
                wr_data_d = data_arr[gnt_idx_c];
                wr_src_d  = SRC_W'(gnt_idx_c);
            end else begin
                // Illegal select: request consumed, nothing written
                state_d   = ST_IDLE;
                wr_en_d   = 1'b0;
                err_sel_d = 1'b1;
            end
        end else begin
            state_d = ST_IDLE;
            wr_en_d = 1'b0;
        end
    end

    // State, pointer and write-port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_src_q  <= '0;
            err_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
            err_sel_q <= err_sel_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_sel  = wr_sel_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_src  = wr_src_q;
    assign bus.err_sel = err_sel_q;

`ifdef REGDEST_STALL_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where a presented write was stalled
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.flush) begin
            stall_cnt_d = '0;
        end else if (wr_en_q && bus.wr_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stat_stall_cnt = stall_cnt_q;
`else
    assign bus.stat_stall_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_regdest_wr_arbiter.sv
// Bench for regdest_wr_arbiter: directed stimulus, a behavioural model of the
// write port checked every cycle, plus hand-computed literal checks.
module tb_regdest_wr_arbiter;
    localparam int NREQ    = 4;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 5;
    localparam int MAX_SEL = 11;
`ifdef REGDEST_STALL_STATS_EN
    localparam int STAT_AFTER_3 = 3;
`else
    localparam int STAT_AFTER_3 = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regdest_wr_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regdest_wr_arbiter #(
        .NUM_REQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_SEL(MAX_SEL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int                m_ptr;
    bit                m_pend;
    bit                m_err;
    logic [3:0]        m_sel;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    int                m_src;
    int                m_cnt;

    // Requester that must be granted now, or -1
    function automatic int pick();
        logic [NREQ-1:0] v;
        if (bus.flush || (m_pend && bus.wr_stall)) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int r;
            r = (m_ptr + k) % NREQ;
            v = NREQ'(bus.req_valid >> r);
            if (v[0]) return r;
        end
        return -1;
    endfunction

    initial begin
        int         g;
        logic [3:0] s;
        m_ptr = 0; m_pend = 0; m_err = 0; m_sel = '0; m_addr = '0; m_data = '0; m_src = 0; m_cnt = 0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                m_ptr = 0; m_pend = 0; m_err = 0; m_sel = '0; m_addr = '0;
                m_data = '0; m_src = 0; m_cnt = 0;
            end
            check("m_wr_en", 32'(bus.wr_en), 32'(m_pend));
            check("m_err_sel", 32'(bus.err_sel), 32'(m_err));
            check("m_stat", 32'(bus.stat_stall_cnt), 32'(m_cnt));
            if (m_pend || !rst_n) begin
                check("m_wr_sel", 32'(bus.wr_sel), 32'(m_sel));
                check("m_wr_addr", 32'(bus.wr_addr), 32'(m_addr));
                check("m_wr_data", 32'(bus.wr_data), 32'(m_data));
                check("m_wr_src", 32'(bus.wr_src), 32'(m_src));
            end
            g = pick();
            check("m_req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
            if (rst_n) begin
`ifdef REGDEST_STALL_STATS_EN
                if (bus.flush) m_cnt = 0;
                else if (m_pend && bus.wr_stall && m_cnt < 65535) m_cnt++;
`endif
                if (bus.flush) begin
                    m_pend = 0; m_ptr = 0; m_err = 0;
                end else if (m_pend && bus.wr_stall) begin
                    m_err = 0;
                end else if (g >= 0) begin
                    m_ptr = (g + 1) % NREQ;
                    s = 4'(bus.req_sel >> (4 * g));
                    if (int'(s) <= MAX_SEL) begin
                        m_pend = 1; m_err = 0; m_sel = s; m_src = g;
                        m_addr = ADDR_W'(bus.req_addr >> (ADDR_W * g));
                        m_data = DATA_W'(bus.req_data >> (DATA_W * g));
                    end else begin
                        m_pend = 0; m_err = 1;
                    end
                end else begin
                    m_pend = 0; m_err = 0;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] s, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        bus.req_sel[4*i +: 4]           = s;
        bus.req_addr[ADDR_W*i +: ADDR_W] = a;
        bus.req_data[DATA_W*i +: DATA_W] = d;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_sel = '0; bus.req_addr = '0; bus.req_data = '0;
        bus.wr_stall = 1'b0; bus.flush = 1'b0;
        nxt();
        nxt();
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_sel", 32'(bus.wr_sel), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_err_sel", 32'(bus.err_sel), 32'd0);
        check("rst_stat", 32'(bus.stat_stall_cnt), 32'd0);
        rst_n = 1'b1;
        nxt();

        // Single write from requester 0
        set_req(0, 4'd0, 5'd7, 16'hABCD);
        bus.req_valid = 4'b0001;
        #1 check("t1_ready", 32'(bus.req_ready), 32'h1);
        nxt();
        bus.req_valid = '0;
        check("t1_wr_en", 32'(bus.wr_en), 32'd1);
        check("t1_wr_sel", 32'(bus.wr_sel), 32'd0);
        check("t1_wr_addr", 32'(bus.wr_addr), 32'd7);
        check("t1_wr_data", 32'(bus.wr_data), 32'hABCD);
        check("t1_wr_src", 32'(bus.wr_src), 32'd0);
        nxt();
        bus.flush = 1'b1;
        nxt();
        bus.flush = 1'b0;

        // All four requesting for 8 cycles; requester 3 uses the top legal code
        for (int i = 0; i < NREQ; i++) set_req(i, 4'(i + 8), 5'(10 + i), 16'(16'h1000 + i));
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 check("t2_ready", 32'(bus.req_ready), 32'd1 << (k % 4));
            if (k > 0) begin
                check("t2_wr_en", 32'(bus.wr_en), 32'd1);
                check("t2_wr_src", 32'(bus.wr_src), 32'((k - 1) % 4));
            end
            nxt();
        end
        bus.req_valid = '0;
        check("t2_last_src", 32'(bus.wr_src), 32'd3);
        check("t2_last_sel", 32'(bus.wr_sel), 32'd11);
        nxt();
        check("t2_idle", 32'(bus.wr_en), 32'd0);

        // Requester 2 (sel 3), then three stalled cycles
        set_req(2, 4'd3, 5'd2, 16'h2222);
        bus.req_valid = 4'b0100;
        #1 check("t3_ready", 32'(bus.req_ready), 32'h4);
        nxt();
        set_req(0, 4'd5, 5'd9, 16'h5555);
        bus.req_valid = 4'b0001;
        bus.wr_stall  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 check("t3_stall_ready", 32'(bus.req_ready), 32'd0);
            check("t3_hold_sel", 32'(bus.wr_sel), 32'd3);
            check("t3_hold_en", 32'(bus.wr_en), 32'd1);
            nxt();
        end
        bus.wr_stall = 1'b0;
        #1 check("t3_last_en", 32'(bus.wr_en), 32'd1);
        check("t3_last_sel", 32'(bus.wr_sel), 32'd3);
        check("t3_regrant", 32'(bus.req_ready), 32'h1);
        check("t3_stat", 32'(bus.stat_stall_cnt), 32'(STAT_AFTER_3));
        nxt();
        check("t3_next_src", 32'(bus.wr_src), 32'd0);
        check("t3_next_data", 32'(bus.wr_data), 32'h5555);

        // Illegal select on requester 1
        set_req(1, 4'd13, 5'd1, 16'hEEEE);
        bus.req_valid = 4'b0010;
        #1 check("t4_ready", 32'(bus.req_ready), 32'h2);
        nxt();
        check("t4_wr_en", 32'(bus.wr_en), 32'd0);
        check("t4_err", 32'(bus.err_sel), 32'd1);
        set_req(1, 4'd6, 5'd3, 16'h6666);
        set_req(2, 4'd7, 5'd4, 16'h7777);
        bus.req_valid = 4'b0110;
        #1 check("t4_ptr_adv", 32'(bus.req_ready), 32'h4);
        nxt();
        check("t4_err_clr", 32'(bus.err_sel), 32'd0);
        check("t4_src", 32'(bus.wr_src), 32'd2);

        // Flush while holding a stalled write
        bus.req_valid = '0;
        bus.wr_stall  = 1'b1;
        nxt();
        check("t5_hold", 32'(bus.wr_en), 32'd1);
        bus.flush = 1'b1;
        set_req(1, 4'd8, 5'd5, 16'h8888);
        set_req(3, 4'd9, 5'd6, 16'h9999);
        bus.req_valid = 4'b1010;
        #1 check("t5_flush_ready", 32'(bus.req_ready), 32'd0);
        nxt();
        bus.flush    = 1'b0;
        bus.wr_stall = 1'b0;
        check("t5_wr_en", 32'(bus.wr_en), 32'd0);
        #1 check("t5_ptr0", 32'(bus.req_ready), 32'h2);
        nxt();
        check("t5_src", 32'(bus.wr_src), 32'd1);
        check("t5_sel", 32'(bus.wr_sel), 32'd8);

        // Asynchronous reset in HOLD
        bus.req_valid = 4'b1000;
        bus.wr_stall  = 1'b1;
        nxt();
        check("t6_hold", 32'(bus.wr_en), 32'd1);
        rst_n = 1'b0;
        #1 check("t6_rst_en", 32'(bus.wr_en), 32'd0);
        check("t6_rst_sel", 32'(bus.wr_sel), 32'd0);
        check("t6_rst_addr", 32'(bus.wr_addr), 32'd0);
        check("t6_rst_src", 32'(bus.wr_src), 32'd0);
        nxt();
        rst_n = 1'b1;
        bus.wr_stall = 1'b0;
        #1 check("t6_post_ready", 32'(bus.req_ready), 32'h8);
        nxt();
        bus.req_valid = '0;
        check("t6_post_src", 32'(bus.wr_src), 32'd3);
        check("t6_post_data", 32'(bus.wr_data), 32'h9999);
        nxt();
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regdest_wr_arbiter.md
Name: regdest_wr_arbiter

Overview:
- Shares the single register-file write port among NUM_REQ writeback requesters: ALU result, load return, link write and exception save.
- Arbitrates round-robin, validates the destination-select code, and drives the 4-bit selection into the destination mux in the single-cycle CPU.
- Write-port outputs are registered.
- Holds the registered write while the register file stalls, and supports a synchronous flush.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 16, write data width
- ADDR_W, 5, explicit destination address width
- MAX_SEL, 11, highest legal destination-select code

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester write request
- req_sel  in  4*NUM_REQ  per-requester select code; 0 = use req_addr, 1..MAX_SEL = fixed destination
- req_addr  in  ADDR_W*NUM_REQ  per-requester explicit destination
- req_data  in  DATA_W*NUM_REQ  per-requester write data
- req_ready  out  NUM_REQ  one-hot grant, combinational
- wr_stall  in  1  register file cannot accept this cycle
- flush  in  1  synchronous discard of pending write plus pointer reset
- wr_en  out  1  registered write strobe
- wr_sel  out  4  registered selection to destination mux
- wr_addr  out  ADDR_W  registered explicit address
- wr_data  out  DATA_W  registered write data
- wr_src  out  3  index of requester owning current write
- err_sel  out  1  one-cycle pulse: illegal select code accepted and dropped
- stat_stall_cnt  out  16  stall statistic (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, wr_src=0, err_sel=0, stat_stall_cnt=0.
  - rr pointer=0; state=IDLE.
- States:
  - IDLE: no write held.
  - WRITE: wr_en=1, presented this cycle.
  - HOLD: wr_en=1, previous cycle stalled.
- Accept condition: can_accept = !flush && (state==IDLE || !wr_stall).
- Arbitration:
  - When can_accept, the block scans req_valid starting at the rr pointer and wraps modulo NUM_REQ.
  - The first valid requester i gets req_ready[i]=1, same cycle, combinational.
  - All other req_ready bits are 0. Exactly zero or one bit is set.
  - Handshake = req_valid[i] && req_ready[i].
  - Requesters hold valid, sel, addr and data stable until handshake.
- On handshake with req_sel<=MAX_SEL:
  - Next cycle: wr_en=1, wr_sel/wr_addr/wr_data/wr_src = captured values; state=WRITE.
  - rr pointer = (i+1) mod NUM_REQ.
- On handshake with req_sel>MAX_SEL:
  - The request is consumed. Next cycle: wr_en=0 (IDLE unless another write is held), err_sel=1 for one cycle.
  - The pointer still advances.
- No handshake and no stall: next cycle wr_en=0, state=IDLE.
- WRITE or HOLD with wr_stall=1:
  - All wr_* outputs hold; state=HOLD; req_ready all 0.
- HOLD with wr_stall=0:
  - The write completes this cycle. A new grant may occur in the same cycle (back-to-back, no bubble).
- Latency: grant to wr_en is 1 cycle. Sustained throughput is 1 write/cycle when unstalled.
- flush=1 (priority over everything except reset):
  - req_ready all 0. Next cycle wr_en=0, state=IDLE, rr pointer=0, err_sel=0.
  - A held write is discarded.
- wr_addr is meaningful only when wr_sel==0. When wr_sel!=0 it still carries the captured req_addr.
- Reset asserted mid-HOLD clears immediately; the pending write is lost.

Optional Feature:
- Macro REGDEST_STALL_STATS_EN.
- Defined:
  - stat_stall_cnt increments by 1 on every cycle with wr_en=1 && wr_stall=1.
  - It saturates at 16'hFFFF and is cleared by reset or flush.
- Undefined: stat_stall_cnt is tied to 0 and no counter logic is synthesized. The port always exists.

Test Plan:
- Reset, then req_valid=4'b0001, sel=0, addr=5'd7, data=16'hABCD → req_ready=4'b0001 same cycle; next cycle wr_en=1, wr_sel=0, wr_addr=7, wr_data=ABCD, wr_src=0.
- req_valid=4'b1111 held for 8 cycles, no stall → grants 0,1,2,3,0,1,2,3; wr_en=1 every cycle after the first; wr_src follows the same order.
- Grant requester 2 (sel=3), then wr_stall=1 for 3 cycles → wr_en/wr_sel=3 held for 4 cycles; req_ready=0 during stall; next grant lands in the first unstalled cycle; stat_stall_cnt=3 with REGDEST_STALL_STATS_EN, 0 without.
- Requester 1 with sel=4'd13 → req_ready[1]=1; next cycle wr_en=0, err_sel=1 for exactly one cycle; next grant search starts at requester 2.
- In HOLD, assert flush for one cycle → next cycle wr_en=0, pointer=0; with req_valid=4'b1010 the following grant goes to requester 1.
- Deassert rst_n asynchronously mid-HOLD → wr_en drops to 0 before the next clock edge; all outputs are at reset values.
